// File: rtl/cluster_pwr_seq.sv
// cluster_pwr_seq: power-up/power-down sequencer for the cluster power domain.
// Drives power switch, clock gate, isolation, reset and fetch enable in a safe
// order and reports busy/state/sticky error.
// Build option: define CLUSTER_PWR_SEQ_TIMEOUT_EN to make PWR_UP and PWR_OFF
// fall into ERR when the power-switch acknowledge does not arrive in time.
module cluster_pwr_seq #(
    parameter int unsigned ISO_DELAY_CYCLES = 4,
    parameter int unsigned RST_HOLD_CYCLES  = 16,
    parameter int unsigned PWR_TIMEOUT      = 1024
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       cluster_pow_i,
    input  logic       cluster_byp_i,
    input  logic       cluster_rstn_i,
    input  logic       cluster_fetch_enable_i,
    input  logic       pwr_ack_i,
    output logic       pwr_req_o,
    output logic       cluster_clk_en_o,
    output logic       cluster_iso_o,
    output logic       cluster_rstn_o,
    output logic       cluster_fetch_enable_o,
    output logic       cluster_byp_o,
    output logic       busy_o,
    output logic [2:0] pwr_state_o,
    output logic       err_o
);

    localparam int unsigned MAX_A   = (ISO_DELAY_CYCLES > RST_HOLD_CYCLES) ?
                                      ISO_DELAY_CYCLES : RST_HOLD_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_A > PWR_TIMEOUT) ? MAX_A : PWR_TIMEOUT;
    localparam int unsigned CW      = $clog2(MAX_CNT);

    localparam logic [CW-1:0] ISO_LAST = CW'(ISO_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_HOLD_CYCLES - 1);
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST  = CW'(PWR_TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        S_OFF      = 3'd0,
        S_PWR_UP   = 3'd1,
        S_CLK_ON   = 3'd2,
        S_RST_HOLD = 3'd3,
        S_ON       = 3'd4,
        S_ISO_ON   = 3'd5,
        S_PWR_OFF  = 3'd6,
        S_ERR      = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          r_rstn, r_fetch;
    logic          req_d, clk_en_d, iso_d, rstn_d, fetch_d, busy_d, err_d;

    // State register, dwell counter, input sampling and registered outputs
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q                <= S_OFF;
            cnt_q                  <= '0;
            r_rstn                 <= 1'b0;
            r_fetch                <= 1'b0;
            pwr_req_o              <= 1'b0;
            cluster_clk_en_o       <= 1'b0;
            cluster_iso_o          <= 1'b1;
            cluster_rstn_o         <= 1'b0;
            cluster_fetch_enable_o <= 1'b0;
            cluster_byp_o          <= 1'b1;
            busy_o                 <= 1'b0;
            err_o                  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
            r_rstn                 <= cluster_rstn_i;
            r_fetch                <= cluster_fetch_enable_i;
            pwr_req_o              <= req_d;
            cluster_clk_en_o       <= clk_en_d;
            cluster_iso_o          <= iso_d;
            cluster_rstn_o         <= rstn_d;
            cluster_fetch_enable_o <= fetch_d;
            busy_o                 <= busy_d;
            err_o                  <= err_d;
            if (state_q == S_OFF || state_q == S_ERR) begin
                cluster_byp_o <= cluster_byp_i;
            end
        end
    end

    assign pwr_state_o = state_q;

    // Next-state decode; earlier conditions in each state take priority
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_OFF: begin
                if (cluster_pow_i) state_d = S_PWR_UP;
            end
            S_PWR_UP: begin
                if (!cluster_pow_i)  state_d = S_PWR_OFF;
                else if (pwr_ack_i)  state_d = S_CLK_ON;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
                else if (cnt_q == TO_LAST) state_d = S_ERR;
`endif
            end
            S_CLK_ON: begin
                if (!cluster_pow_i)          state_d = S_ISO_ON;
                else if (cnt_q == ISO_LAST)  state_d = S_RST_HOLD;
            end
            S_RST_HOLD: begin
                if (!cluster_pow_i)          state_d = S_ISO_ON;
                else if (cnt_q == RST_LAST)  state_d = S_ON;
            end
            S_ON: begin
                if (!pwr_ack_i)           state_d = S_ERR;
                else if (!cluster_pow_i)  state_d = S_ISO_ON;
            end
            S_ISO_ON: begin
                if (cnt_q == ISO_LAST) state_d = S_PWR_OFF;
            end
            S_PWR_OFF: begin
                if (!pwr_ack_i) state_d = S_OFF;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
                else if (cnt_q == TO_LAST) state_d = S_ERR;
`endif
            end
            S_ERR: begin
                if (!cluster_pow_i && !pwr_ack_i) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    // Output decode from the next state so outputs flop alongside the state
    always_comb begin
        req_d    = 1'b0;
        clk_en_d = 1'b0;
        iso_d    = 1'b1;
        rstn_d   = 1'b0;
        fetch_d  = 1'b0;
        busy_d   = 1'b0;
        err_d    = 1'b0;
        unique case (state_d)
            S_OFF: ;
            S_PWR_UP: begin
                req_d  = 1'b1;
                busy_d = 1'b1;
            end
            S_CLK_ON: begin
                req_d    = 1'b1;
                clk_en_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_RST_HOLD: begin
                req_d    = 1'b1;
                clk_en_d = 1'b1;
                iso_d    = 1'b0;
                busy_d   = 1'b1;
            end
            S_ON: begin
                req_d    = 1'b1;
                clk_en_d = 1'b1;
                iso_d    = 1'b0;
                rstn_d   = r_rstn;
                fetch_d  = r_rstn & r_fetch;
            end
            S_ISO_ON: begin
                req_d    = 1'b1;
                clk_en_d = 1'b1;
                busy_d   = 1'b1;
            end
            S_PWR_OFF: begin
                busy_d = 1'b1;
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Directed self-checking bench for cluster_pwr_seq (default parameters).
// Output vector layout: {req, clk_en, iso, rstn, fetch, byp, busy, err, state[2:0]}.
module tb_cluster_pwr_seq;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       pow = 1'b0, byp = 1'b1, rstn_i = 1'b0, fetch_i = 1'b0, ack = 1'b0;
    logic       pwr_req_o, clk_en_o, iso_o, rstn_o, fetch_o, byp_o, busy_o, err_o;
    logic [2:0] state_o;

    int checks = 0;
    int failures = 0;

    cluster_pwr_seq #(
        .ISO_DELAY_CYCLES(4),
        .RST_HOLD_CYCLES (16),
        .PWR_TIMEOUT     (1024)
    ) dut (
        .HCLK                  (HCLK),
        .HRESETn               (HRESETn),
        .cluster_pow_i         (pow),
        .cluster_byp_i         (byp),
        .cluster_rstn_i        (rstn_i),
        .cluster_fetch_enable_i(fetch_i),
        .pwr_ack_i             (ack),
        .pwr_req_o             (pwr_req_o),
        .cluster_clk_en_o      (clk_en_o),
        .cluster_iso_o         (iso_o),
        .cluster_rstn_o        (rstn_o),
        .cluster_fetch_enable_o(fetch_o),
        .cluster_byp_o         (byp_o),
        .busy_o                (busy_o),
        .pwr_state_o           (state_o),
        .err_o                 (err_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    function automatic logic [10:0] outs();
        return {pwr_req_o, clk_en_o, iso_o, rstn_o, fetch_o, byp_o, busy_o, err_o, state_o};
    endfunction

    // Drive from OFF to ON with ack already high: ON after 22 edges
    task automatic go_on();
        pow = 1'b1; ack = 1'b1; rstn_i = 1'b1; fetch_i = 1'b1;
        repeat (22) tick();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; byp = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_0_000) begin
            failures++; $display("FAIL reset_vals got=%b want=%b", outs(), 11'b00100_1_0_0_000);
        end
        HRESETn = 1'b1;
        tick();
        checks++;
        if (outs() !== 11'b00100_0_0_0_000) begin
            failures++; $display("FAIL byp_load_off got=%b want=%b", outs(), 11'b00100_0_0_0_000);
        end
        byp = 1'b1;
        tick();
        checks++;
        if (byp_o !== 1'b1) begin
            failures++; $display("FAIL byp_reload got=%b want=1", byp_o);
        end
    endtask

    task automatic test_power_up();
        rstn_i = 1'b1; fetch_i = 1'b1; pow = 1'b1; ack = 1'b0;
        tick();  // edge 0
        checks++;
        if (outs() !== 11'b10100_1_1_0_001) begin
            failures++; $display("FAIL pwr_up_entry got=%b want=%b", outs(), 11'b10100_1_1_0_001);
        end
        byp = 1'b0;
        repeat (3) tick();  // edges 1..3
        checks++;
        if (outs() !== 11'b10100_1_1_0_001) begin
            failures++; $display("FAIL pwr_up_wait_byp_hold got=%b want=%b", outs(), 11'b10100_1_1_0_001);
        end
        ack = 1'b1;
        tick();  // edge 4
        checks++;
        if (outs() !== 11'b11100_1_1_0_010) begin
            failures++; $display("FAIL clk_on_edge4 got=%b want=%b", outs(), 11'b11100_1_1_0_010);
        end
        repeat (3) tick();  // edges 5..7
        checks++;
        if (outs() !== 11'b11100_1_1_0_010) begin
            failures++; $display("FAIL clk_on_edge7 got=%b want=%b", outs(), 11'b11100_1_1_0_010);
        end
        tick();  // edge 8
        checks++;
        if (outs() !== 11'b11000_1_1_0_011) begin
            failures++; $display("FAIL iso_release_edge8 got=%b want=%b", outs(), 11'b11000_1_1_0_011);
        end
        repeat (15) tick();  // edges 9..23
        checks++;
        if (outs() !== 11'b11000_1_1_0_011) begin
            failures++; $display("FAIL rst_hold_edge23 got=%b want=%b", outs(), 11'b11000_1_1_0_011);
        end
        tick();  // edge 24
        checks++;
        if (outs() !== 11'b11011_1_0_0_100) begin
            failures++; $display("FAIL on_edge24 got=%b want=%b", outs(), 11'b11011_1_0_0_100);
        end
        // Two-edge latency of software reset / fetch enable in ON
        fetch_i = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b11011_1_0_0_100) begin
            failures++; $display("FAIL fetch_lat1 got=%b want=%b", outs(), 11'b11011_1_0_0_100);
        end
        tick();
        checks++;
        if (outs() !== 11'b11010_1_0_0_100) begin
            failures++; $display("FAIL fetch_lat2 got=%b want=%b", outs(), 11'b11010_1_0_0_100);
        end
        fetch_i = 1'b1; rstn_i = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b11010_1_0_0_100) begin
            failures++; $display("FAIL rstn_lat1 got=%b want=%b", outs(), 11'b11010_1_0_0_100);
        end
        tick();
        checks++;
        if (outs() !== 11'b11000_1_0_0_100) begin
            failures++; $display("FAIL rstn_lat2 got=%b want=%b", outs(), 11'b11000_1_0_0_100);
        end
        rstn_i = 1'b1;
        tick();
        tick();
        checks++;
        if (outs() !== 11'b11011_1_0_0_100) begin
            failures++; $display("FAIL rstn_restore got=%b want=%b", outs(), 11'b11011_1_0_0_100);
        end
    endtask

    task automatic test_power_down();
        pow = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b11100_1_1_0_101) begin
            failures++; $display("FAIL iso_on_entry got=%b want=%b", outs(), 11'b11100_1_1_0_101);
        end
        pow = 1'b1;  // must be ignored in ISO_ON
        repeat (3) tick();
        checks++;
        if (outs() !== 11'b11100_1_1_0_101) begin
            failures++; $display("FAIL iso_on_ignore_pow got=%b want=%b", outs(), 11'b11100_1_1_0_101);
        end
        pow = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_1_0_110) begin
            failures++; $display("FAIL pwr_off_entry got=%b want=%b", outs(), 11'b00100_1_1_0_110);
        end
        ack = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_0_000) begin
            failures++; $display("FAIL off_after_ack_drop got=%b want=%b", outs(), 11'b00100_1_0_0_000);
        end
        tick();
        checks++;
        if (outs() !== 11'b00100_0_0_0_000) begin
            failures++; $display("FAIL byp_load_after_off got=%b want=%b", outs(), 11'b00100_0_0_0_000);
        end
        byp = 1'b1;
        tick();
    endtask

    task automatic test_ack_loss();
        go_on();
        checks++;
        if (outs() !== 11'b11011_1_0_0_100) begin
            failures++; $display("FAIL ackloss_on got=%b want=%b", outs(), 11'b11011_1_0_0_100);
        end
        ack = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_1_111) begin
            failures++; $display("FAIL ackloss_err got=%b want=%b", outs(), 11'b00100_1_0_1_111);
        end
        byp = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_0_0_1_111) begin
            failures++; $display("FAIL err_hold_byp_load got=%b want=%b", outs(), 11'b00100_0_0_1_111);
        end
        pow = 1'b0; ack = 1'b1;
        tick();
        checks++;
        if (outs() !== 11'b00100_0_0_1_111) begin
            failures++; $display("FAIL err_hold_ack_high got=%b want=%b", outs(), 11'b00100_0_0_1_111);
        end
        ack = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_0_0_0_000) begin
            failures++; $display("FAIL err_exit got=%b want=%b", outs(), 11'b00100_0_0_0_000);
        end
        byp = 1'b1;
        tick();
        // ack lost together with pow drop in ON
        go_on();
        pow = 1'b0; ack = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_1_111) begin
            failures++; $display("FAIL simul_ackloss_powdrop got=%b want=%b", outs(), 11'b00100_1_0_1_111);
        end
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_0_000) begin
            failures++; $display("FAIL simul_err_exit got=%b want=%b", outs(), 11'b00100_1_0_0_000);
        end
    endtask

    task automatic test_rst_hold_abort();
        logic seen_rstn;
        pow = 1'b1; ack = 1'b1; rstn_i = 1'b1; fetch_i = 1'b1;
        repeat (6) tick();
        checks++;
        if (outs() !== 11'b11000_1_1_0_011) begin
            failures++; $display("FAIL abort_in_rst_hold got=%b want=%b", outs(), 11'b11000_1_1_0_011);
        end
        seen_rstn = rstn_o;
        pow = 1'b0;
        tick();
        seen_rstn |= rstn_o;
        checks++;
        if (outs() !== 11'b11100_1_1_0_101) begin
            failures++; $display("FAIL abort_iso_on got=%b want=%b", outs(), 11'b11100_1_1_0_101);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_rstn |= rstn_o;
        end
        checks++;
        if (outs() !== 11'b00100_1_1_0_110) begin
            failures++; $display("FAIL abort_pwr_off got=%b want=%b", outs(), 11'b00100_1_1_0_110);
        end
        ack = 1'b0;
        tick();
        seen_rstn |= rstn_o;
        checks++;
        if (outs() !== 11'b00100_1_0_0_000) begin
            failures++; $display("FAIL abort_off got=%b want=%b", outs(), 11'b00100_1_0_0_000);
        end
        checks++;
        if (seen_rstn !== 1'b0) begin
            failures++; $display("FAIL abort_rstn_never_high got=%b want=0", seen_rstn);
        end
    endtask

    task automatic test_pwrup_abort();
        pow = 1'b1; ack = 1'b0;
        tick();
        pow = 1'b0; ack = 1'b1;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_1_0_110) begin
            failures++; $display("FAIL pwrup_ack_and_powdrop got=%b want=%b", outs(), 11'b00100_1_1_0_110);
        end
        ack = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_0_000) begin
            failures++; $display("FAIL pwrup_abort_off got=%b want=%b", outs(), 11'b00100_1_0_0_000);
        end
    endtask

    task automatic test_mid_reset();
        pow = 1'b1; ack = 1'b1;
        tick();
        tick();
        checks++;
        if (outs() !== 11'b11100_1_1_0_010) begin
            failures++; $display("FAIL midrst_clk_on got=%b want=%b", outs(), 11'b11100_1_1_0_010);
        end
        byp = 1'b0; HRESETn = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_0_000) begin
            failures++; $display("FAIL midrst_vals got=%b want=%b", outs(), 11'b00100_1_0_0_000);
        end
        HRESETn = 1'b1; pow = 1'b0; ack = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_0_0_0_000) begin
            failures++; $display("FAIL midrst_byp_off got=%b want=%b", outs(), 11'b00100_0_0_0_000);
        end
        byp = 1'b1;
        tick();
    endtask

    task automatic test_timeout();
        pow = 1'b1; ack = 1'b0;
        tick();  // edge 0, PWR_UP
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
        repeat (1023) tick();
        checks++;
        if (outs() !== 11'b10100_1_1_0_001) begin
            failures++; $display("FAIL timeout_edge1023 got=%b want=%b", outs(), 11'b10100_1_1_0_001);
        end
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_1_111) begin
            failures++; $display("FAIL timeout_err got=%b want=%b", outs(), 11'b00100_1_0_1_111);
        end
        pow = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_0_000) begin
            failures++; $display("FAIL timeout_exit got=%b want=%b", outs(), 11'b00100_1_0_0_000);
        end
`else
        repeat (1100) tick();
        checks++;
        if (outs() !== 11'b10100_1_1_0_001) begin
            failures++; $display("FAIL no_timeout_wait got=%b want=%b", outs(), 11'b10100_1_1_0_001);
        end
        pow = 1'b0;
        tick();
        checks++;
        if (outs() !== 11'b00100_1_1_0_110) begin
            failures++; $display("FAIL no_timeout_pwr_off got=%b want=%b", outs(), 11'b00100_1_1_0_110);
        end
        tick();
        checks++;
        if (outs() !== 11'b00100_1_0_0_000) begin
            failures++; $display("FAIL no_timeout_off got=%b want=%b", outs(), 11'b00100_1_0_0_000);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_ack_loss();
        test_rst_hold_abort();
        test_pwrup_abort();
        test_mid_reset();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
